// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: state encoding,
// per-digit radix and the width of one BCD digit.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_t;

   // Even digit positions count 0-9, odd positions count 0-5 (mm:ss style).
   function automatic int radix(input int i);
      return ((i % 2) == 0) ? 10 : 6;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that divides the system clock down to the count tick rate.
// The counter only advances while enabled and is cleared otherwise, so a
// partially elapsed tick period is thrown away whenever counting stops.
module tick_gen #(
   parameter int CLK_DIV = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == LAST);

   // Free-run from 0 to CLK_DIV-1 while enabled; hold at zero when disabled.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// Mixed-radix BCD stopwatch/timer with start/pause, count-down from a
// preloaded value, lap freeze of the display and wrap-or-saturate overflow.
// Digit 0 is the least significant digit and sits in bits [3:0].
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV    = 500000,
   parameter int NUM_DIGITS = 4,
   parameter int WRAP       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic                          clear,
   input  logic                          load,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
   input  logic                          down,
   input  logic                          lap,
   output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
   output logic                          run,
   output logic                          done,
   output logic                          lap_held,
   output logic                          wrap
);

   localparam int W = DIGIT_W * NUM_DIGITS;

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   count;
   logic [W-1:0]   count_next;
   logic [W-1:0]   snapshot;
   logic [W-1:0]   snapshot_next;
   logic           lap_held_next;
   logic           wrap_next;
   logic           tick;

   logic [W-1:0]   inc_val;
   logic [W-1:0]   dec_val;
   logic [W-1:0]   load_clamped;
   logic [NUM_DIGITS:0] carry;
   logic [NUM_DIGITS:0] borrow;

   logic           at_max;
   logic           count_zero;
   logic           dec_zero;
   logic           load_ok;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst || clear),
      .en   (state == RUN),
      .tick (tick)
   );

   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   // Per-digit increment/decrement with a ripple carry/borrow chain, plus
   // clamping of the preload value to each digit's own radix.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(radix(i) - 1);

      logic [DIGIT_W-1:0] d;
      logic [DIGIT_W-1:0] ld;

      assign d  = count[i*DIGIT_W +: DIGIT_W];
      assign ld = load_val[i*DIGIT_W +: DIGIT_W];

      assign inc_val[i*DIGIT_W +: DIGIT_W] =
         !carry[i]    ? d :
         (d == DMAX)  ? '0 : d + DIGIT_W'(1);
      assign carry[i+1] = carry[i] && (d == DMAX);

      assign dec_val[i*DIGIT_W +: DIGIT_W] =
         !borrow[i]   ? d :
         (d == '0)    ? DMAX : d - DIGIT_W'(1);
      assign borrow[i+1] = borrow[i] && (d == '0);

      assign load_clamped[i*DIGIT_W +: DIGIT_W] = (ld > DMAX) ? DMAX : ld;
   end

   // A full carry chain means every digit is at its maximum; a full borrow
   // chain means every digit is zero.
   assign at_max     = carry[NUM_DIGITS];
   assign count_zero = borrow[NUM_DIGITS];
   assign dec_zero   = (dec_val == '0);
   assign load_ok    = load && ((state == IDLE) || (state == PAUSE));

   // Next-state and next-datapath decisions, highest priority first:
   // clear, then an accepted load, then go, then the count tick. Lap is
   // independent of those and only blocked by clear (or reset).
   always_comb begin
      state_next    = state;
      count_next    = count;
      snapshot_next = snapshot;
      lap_held_next = lap_held;
      wrap_next     = 1'b0;

      if (clear) begin
         state_next    = IDLE;
         count_next    = '0;
         lap_held_next = 1'b0;
      end else begin
         if (lap) begin
            lap_held_next = !lap_held;
            if (!lap_held) begin
               snapshot_next = count;
            end
         end

         if (load_ok) begin
            count_next = load_clamped;
         end else if (go) begin
            case (state)
               IDLE, PAUSE: begin
                  if (!(down && count_zero)) begin
                     state_next = RUN;
                  end
               end
               RUN:     state_next = PAUSE;
               default: state_next = state;
            endcase
         end else if (tick) begin
            if (!down) begin
               if (at_max) begin
                  if (WRAP != 0) begin
                     count_next = '0;
                     wrap_next  = 1'b1;
                  end else begin
                     state_next = DONE;
                  end
               end else begin
                  count_next = inc_val;
               end
            end else begin
               count_next = dec_val;
               if (dec_zero) begin
                  state_next = DONE;
               end
            end
         end
      end
   end

   // State register of the run-control FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Count, lap snapshot, lap freeze flag and the one-cycle wrap pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         snapshot <= '0;
         lap_held <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         count    <= count_next;
         snapshot <= snapshot_next;
         lap_held <= lap_held_next;
         wrap     <= wrap_next;
      end
   end

   assign digits = lap_held ? snapshot : count;
   assign run    = (state == RUN);
   assign done   = (state == DONE);

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised BCD stopwatch/timer that generalises the 4-digit free-running mm:ss counter. Adds start/pause control, count-down mode with preload, lap freeze, wrap-or-saturate overflow, and an internal prescaler that divides the system clock. It sits between board clock/keys and the per-digit seven-segment decoders.

## Interface

- CLK_DIV, default 500000: system clocks per count tick (50 MHz → 100 Hz); ≥2.
- NUM_DIGITS, default 4: BCD digits, even, ≥2.
  - Even digit index: radix 10.
  - Odd digit index: radix 6.
- WRAP, default 1: up-count overflow behaviour.
  - 1: wrap to zero.
  - 0: saturate and stop.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  single-cycle pulse: start/resume/pause toggle.
- clear  in  1  single-cycle pulse: return to zero and idle.
- load  in  1  single-cycle pulse: preload the count from load_val.
- load_val  in  4*NUM_DIGITS  BCD preload value; digit 0 in bits [3:0].
- down  in  1  level input; 1 = count down.
- lap  in  1  single-cycle pulse: toggle display freeze.
- digits  out  4*NUM_DIGITS  displayed BCD value; digit 0 in bits [3:0].
- run  out  1  high in RUN.
- done  out  1  high in DONE.
- lap_held  out  1  display is frozen.
- wrap  out  1  one-cycle pulse on up-count wrap.

## Operation

- States:
  - IDLE: reset/clear state, count = 0.
  - RUN: counting.
  - PAUSE: count held.
  - DONE: terminal state.
- Input priority per edge: rst > clear > load > go > lap > tick.
- clear:
  - Any state → IDLE.
  - Sets count to 0 and lap_held to 0.
- load:
  - Accepted only in IDLE or PAUSE; ignored in RUN and DONE.
  - State is unchanged.
  - A digit exceeding radix−1 is clamped to radix−1.
- go:
  - IDLE/PAUSE → RUN.
  - Ignored if down = 1 and count = 0.
  - RUN → PAUSE.
  - Ignored in DONE.
- Tick, up count (down = 0):
  - Mixed-radix increment of the count.
  - At all-max (e.g. 5959) with WRAP = 1: count goes to 0, wrap pulses, state stays RUN.
  - At all-max with WRAP = 0: count holds, state → DONE.
- Tick, down count (down = 1):
  - Mixed-radix decrement; a digit borrows from radix−1.
  - A result of 0 → DONE on the same edge.
- down is sampled at each tick, so a mid-run change takes effect from the next tick.
- lap:
  - Toggles lap_held.
  - On the 0→1 toggle, the current count is captured into a snapshot register.
  - Accepted in any state except during rst/clear.
- digits = lap_held ? snapshot : count (combinational mux of registers).

## Timing

- Reset values: count = 0, snapshot = 0, prescaler = 0, state = IDLE.
  - Outputs: digits = 0, run = 0, done = 0, lap_held = 0, wrap = 0.
- Prescaler:
  - Counts only in RUN and is cleared in every other state, so a partial tick is discarded on pause.
  - tick = (state == RUN) && (prescaler == CLK_DIV−1); the prescaler then returns to 0.
- After go is sampled into RUN at edge E, the first count change occurs at edge E+CLK_DIV, then every CLK_DIV cycles.
- Count, state, wrap, done and run all update on the tick edge; no extra pipeline stage.
- wrap is high for exactly the one cycle after the wrapping edge.
- go and tick on the same edge: go wins, and the count does not change on that edge.
- rst or clear mid-run: outputs are at reset values in the cycle after the edge.
- Prescaler width: $clog2(CLK_DIV).

## Structure

- Package stopwatch_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - Function radix(i) returning 10/6.
  - BCD digit width constant (4).
- Sub-module tick_gen:
  - Parameter CLK_DIV.
  - Inputs clk, rst, en; output tick.
  - Counter cleared when en = 0.
- Top-level contents:
  - FSM.
  - Generate loop of per-digit increment/decrement with carry/borrow chain.
  - Load clamp.
  - Lap snapshot.

## Test plan

All scenarios use CLK_DIV = 4 and NUM_DIGITS = 4; digits values are given in hex.

1. rst, then go, then 40 cycles → digits = 0x0010, run = 1; first change exactly 4 cycles after go.
2. load 0x0059, go, one tick → 0x0100.
   - load 0x5959, go, one tick, WRAP = 1 → 0x0000, wrap pulsed for 1 cycle, run = 1.
   - Same with WRAP = 0 → 0x5959 held, done = 1, run = 0.
3. down = 1, load 0x0100, go, one tick → 0x0059.
   - load 0x0002, go, two ticks → 0x0000, done = 1.
   - go with count = 0 and down = 1 → stays IDLE.
4. Running, lap at count 0x0003 → digits hold 0x0003, lap_held = 1 while the internal count reaches 0x0007.
   - lap again → digits = 0x0007 immediately.
5. go mid-prescale (prescaler = 2) → PAUSE, no change for 20 cycles.
   - go again → next change exactly 4 cycles later.
6. load 0x0A7F in IDLE → 0x0959.
   - clear+go on the same edge mid-run → IDLE, 0x0000.
   - rst mid-run → all outputs 0 the next cycle.
